// File: rtl/i_fetch_ctrl.sv
// i_fetch_ctrl: PC owner and fetch sequencer feeding decode through a 2-entry buffer
// that absorbs the one-cycle registered I-memory read latency.
module i_fetch_ctrl #(
    parameter int ADDR_W = 8,
    parameter int ISIZE = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [ISIZE-1:0]  imem_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [ISIZE-1:0]  inst_out,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              idle
);
    logic [ADDR_W-1:0] pc_q, pc_d, inflight_pc_q, inflight_pc_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        count_q, count_d;
    logic              rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [ISIZE-1:0]  inst_q [2];
    logic [ISIZE-1:0]  inst_d [2];
    logic [ADDR_W-1:0] ipc_q [2];
    logic [ADDR_W-1:0] ipc_d [2];
    logic              pop, push, issue;
    logic [1:0]        occ;

    always_comb begin
        pop = (count_q != 2'd0) & inst_ready;
        push = inflight_q & !redirect_valid;
        // slots still claimed after this edge; a new issue needs one free
        occ = count_q + {1'b0, inflight_q} - {1'b0, pop};
        issue = fetch_en & !redirect_valid & (occ < 2'd2);
        pc_d = redirect_valid ? redirect_pc : issue ? pc_q + ADDR_W'(1) : pc_q;
        inflight_d = issue;
        inflight_pc_d = issue ? pc_q : inflight_pc_q;
        count_d = redirect_valid ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
        rd_ptr_d = !redirect_valid & (rd_ptr_q ^ pop);
        wr_ptr_d = !redirect_valid & (wr_ptr_q ^ push);
        inst_d = inst_q;
        ipc_d = ipc_q;
        if (push) begin
            inst_d[wr_ptr_q] = imem_data;
            ipc_d[wr_ptr_q] = inflight_pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
            inflight_q <= 1'b0;
            inflight_pc_q <= '0;
            count_q <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            inst_q <= '{default: '0};
            ipc_q <= '{default: '0};
        end else begin
            pc_q <= pc_d;
            inflight_q <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            inst_q <= inst_d;
            ipc_q <= ipc_d;
        end
    end

    assign imem_addr = pc_q;
    assign inst_valid = count_q != 2'd0;
    assign inst_out = inst_q[rd_ptr_q];
    assign inst_pc = ipc_q[rd_ptr_q];
    assign idle = (count_q == 2'd0) & !inflight_q;
endmodule

// File: tb/tb_i_fetch_ctrl.sv
// tb_i_fetch_ctrl: directed vector bench for i_fetch_ctrl with a registered-read I-memory model.
module tb_i_fetch_ctrl;
    typedef struct {
        logic        rst, en, rv;
        logic [7:0]  rpc;
        logic        rdy, ev;
        logic [7:0]  epc;
        logic [15:0] einst;
        logic [7:0]  eaddr;
        logic        eidle, hd;
    } vec_t;

    logic clk = 1'b0;
    logic rst, fetch_en, redirect_valid, inst_ready, inst_valid, idle;
    logic [7:0] redirect_pc, imem_addr, inst_pc;
    logic [15:0] imem_data, inst_out;
    logic [15:0] mem [256];
    int n_chk = 0;
    int n_fail = 0;

    i_fetch_ctrl #(.ADDR_W(8), .ISIZE(16), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_data(imem_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out),
        .inst_pc(inst_pc), .idle(idle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) imem_data <= mem[imem_addr];

    function automatic vec_t mk(logic r, logic e, logic rv, logic [7:0] rpc, logic rdy, logic ev,
                                logic [7:0] epc, logic [15:0] ei, logic [7:0] ea, logic eid, logic hd);
        vec_t v;
        v.rst = r; v.en = e; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.ev = ev;
        v.epc = epc; v.einst = ei; v.eaddr = ea; v.eidle = eid; v.hd = hd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        rst = v.rst; fetch_en = v.en; redirect_valid = v.rv; redirect_pc = v.rpc; inst_ready = v.rdy;
        @(posedge clk);
        #1;
        chk({tag, ".valid"}, 32'(inst_valid), 32'(v.ev));
        chk({tag, ".addr"}, 32'(imem_addr), 32'(v.eaddr));
        chk({tag, ".idle"}, 32'(idle), 32'(v.eidle));
        if (v.hd) begin
            chk({tag, ".pc"}, 32'(inst_pc), 32'(v.epc));
            chk({tag, ".inst"}, 32'(inst_out), 32'(v.einst));
        end
    endtask

    initial begin
        vec_t tbl [$];
        for (int i = 0; i < 256; i++) mem[i] = {8'(i), 8'h5A};
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
        // reset, then streaming with inst_ready high
        tbl.push_back(mk(1, 1, 0, 8'h00, 1, 0, 8'h00, 16'h0000, 8'h00, 1, 1));
        tbl.push_back(mk(0, 1, 0, 8'h00, 1, 0, 8'h00, 16'h0000, 8'h01, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 1, 1, 8'h00, 16'h1111, 8'h02, 0, 1));
        tbl.push_back(mk(0, 1, 0, 8'h00, 1, 1, 8'h01, 16'h2222, 8'h03, 0, 1));
        tbl.push_back(mk(0, 1, 0, 8'h00, 1, 1, 8'h02, 16'h3333, 8'h04, 0, 1));
        tbl.push_back(mk(0, 1, 0, 8'h00, 1, 1, 8'h03, 16'h4444, 8'h05, 0, 1));
        // five cycles of backpressure: head and address frozen
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 1, 0, 8'h00, 0, 1, 8'h03, 16'h4444, 8'h05, 0, 1));
        tbl.push_back(mk(0, 1, 0, 8'h00, 1, 1, 8'h04, 16'h045A, 8'h06, 0, 1));
        tbl.push_back(mk(0, 1, 0, 8'h00, 1, 1, 8'h05, 16'h055A, 8'h07, 0, 1));
        tbl.push_back(mk(0, 1, 0, 8'h00, 1, 1, 8'h06, 16'h065A, 8'h08, 0, 1));
        // redirect to 0x40 while streaming
        tbl.push_back(mk(0, 1, 1, 8'h40, 1, 0, 8'h00, 16'h0000, 8'h40, 1, 0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 1, 0, 8'h00, 16'h0000, 8'h41, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 1, 1, 8'h40, 16'h405A, 8'h42, 0, 1));
        tbl.push_back(mk(0, 1, 0, 8'h00, 1, 1, 8'h41, 16'h415A, 8'h43, 0, 1));
        // redirect to 0xFE and wrap through 0x00
        tbl.push_back(mk(0, 1, 1, 8'hFE, 1, 0, 8'h00, 16'h0000, 8'hFE, 1, 0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 1, 0, 8'h00, 16'h0000, 8'hFF, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 1, 1, 8'hFE, 16'hFE5A, 8'h00, 0, 1));
        tbl.push_back(mk(0, 1, 0, 8'h00, 1, 1, 8'hFF, 16'hFF5A, 8'h01, 0, 1));
        tbl.push_back(mk(0, 1, 0, 8'h00, 1, 1, 8'h00, 16'h1111, 8'h02, 0, 1));
        tbl.push_back(mk(0, 1, 0, 8'h00, 1, 1, 8'h01, 16'h2222, 8'h03, 0, 1));
        foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));

        // fill the buffer, then redirect with inst_ready in the same cycle
        apply(mk(0, 1, 0, 8'h00, 0, 1, 8'h01, 16'h2222, 8'h03, 0, 1), "full");
        apply(mk(0, 1, 1, 8'h10, 1, 0, 8'h00, 16'h0000, 8'h10, 1, 0), "flush");
        apply(mk(0, 1, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 8'h11, 0, 0), "refill0");
        apply(mk(0, 1, 0, 8'h00, 0, 1, 8'h10, 16'h105A, 8'h12, 0, 1), "refill1");
        apply(mk(0, 1, 0, 8'h00, 0, 1, 8'h10, 16'h105A, 8'h12, 0, 1), "refill2");
        // reset with a full buffer; stale memory data afterwards must be ignored
        apply(mk(1, 1, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 8'h00, 1, 1), "rst_mid");
        apply(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 8'h00, 1, 1), "post_rst");

        // fetch gate: drain with fetch_en low, then resume sequentially
        apply(mk(0, 1, 0, 8'h00, 1, 0, 8'h00, 16'h0000, 8'h01, 0, 0), "g0");
        apply(mk(0, 1, 0, 8'h00, 1, 1, 8'h00, 16'h1111, 8'h02, 0, 1), "g1");
        apply(mk(0, 1, 0, 8'h00, 1, 1, 8'h01, 16'h2222, 8'h03, 0, 1), "g2");
        apply(mk(0, 0, 0, 8'h00, 1, 1, 8'h02, 16'h3333, 8'h03, 0, 1), "g3");
        apply(mk(0, 0, 0, 8'h00, 1, 0, 8'h00, 16'h0000, 8'h03, 1, 0), "g4");
        apply(mk(0, 0, 0, 8'h00, 1, 0, 8'h00, 16'h0000, 8'h03, 1, 0), "g5");
        apply(mk(0, 1, 0, 8'h00, 1, 0, 8'h00, 16'h0000, 8'h04, 0, 0), "g6");
        apply(mk(0, 1, 0, 8'h00, 1, 1, 8'h03, 16'h4444, 8'h05, 0, 1), "g7");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
